// File: rtl/rfid_packet_assembler_if.sv
// Bit-stream and packet signals between the demodulator, rfid_packet_assembler and rfid_decode.
interface rfid_packet_assembler_if;
  logic         bit_in;
  logic         bit_valid;
  logic         frame_start;
  logic         frame_end;
  logic [127:0] packet_out;
  logic [1:0]   op_code;
  logic         packet_rdy;
  logic [7:0]   bit_count;
  logic         overflow_err;
  logic         short_err;
  logic         crc_ok;

  modport master (
    output bit_in, bit_valid, frame_start, frame_end,
    input  packet_out, op_code, packet_rdy, bit_count, overflow_err, short_err, crc_ok
  );

  modport slave (
    input  bit_in, bit_valid, frame_start, frame_end,
    output packet_out, op_code, packet_rdy, bit_count, overflow_err, short_err, crc_ok
  );
endinterface

// File: rtl/rfid_packet_assembler.sv
// Deserialises reader-to-tag command bits into a right-justified packet and pulses packet_rdy.
// Optional RFID_CRC16_CHECK_EN adds a CRC-16/CCITT residue check; otherwise crc_ok is tied 1.
module rfid_packet_assembler #(
  parameter int unsigned MAX_BITS = 128,
  parameter int unsigned MIN_BITS = 4,
  parameter int unsigned RDY_HOLD = 2
) (
  input logic                   clock,
  input logic                   reset_n,
  rfid_packet_assembler_if.slave bus
);

  localparam logic [7:0] CntSat   = 8'(MAX_BITS + 1);
  localparam logic [7:0] CntMax   = 8'(MAX_BITS);
  localparam logic [7:0] CntMin   = 8'(MIN_BITS);
  localparam logic [7:0] HoldLast = 8'(RDY_HOLD - 1);

  typedef enum logic [1:0] {StIdle, StRecv, StHold} state_e;

  state_e       state_q;
  logic [127:0] shreg_q, shreg_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [1:0]   op_q, op_d;
  logic [7:0]   hold_q;
  logic [127:0] pkt_q;
  logic [1:0]   opc_q;
  logic [7:0]   len_q;
  logic         rdy_q, ovf_q, short_q;
  logic         len_ok;
  logic         accept;

  // Next-state values include a bit arriving in the same cycle as frame_end.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (bus.bit_valid) begin
      shreg_d = {shreg_q[126:0], bus.bit_in};
      if (cnt_q != CntSat) cnt_d = cnt_q + 8'd1;
      if (cnt_q == 8'd0) op_d[1] = bus.bit_in;
      if (cnt_q == 8'd1) op_d[0] = bus.bit_in;
    end
    len_ok = (cnt_d >= CntMin) && (cnt_d <= CntMax);
  end

  assign accept = (state_q == StRecv) && !bus.frame_start && bus.frame_end && len_ok;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      hold_q  <= '0;
      pkt_q   <= '0;
      opc_q   <= '0;
      len_q   <= '0;
      rdy_q   <= 1'b0;
      ovf_q   <= 1'b0;
      short_q <= 1'b0;
    end else if (bus.frame_start) begin
      // A new delimiter always wins: partial frames and pending rdy pulses are abandoned.
      state_q <= StRecv;
      shreg_q <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      rdy_q   <= 1'b0;
      ovf_q   <= 1'b0;
      short_q <= 1'b0;
    end else begin
      case (state_q)
        StRecv: begin
          shreg_q <= shreg_d;
          cnt_q   <= cnt_d;
          op_q    <= op_d;
          if (bus.frame_end) begin
            if (len_ok) begin
              pkt_q   <= shreg_d;
              opc_q   <= op_d;
              len_q   <= cnt_d;
              rdy_q   <= 1'b1;
              hold_q  <= HoldLast;
              state_q <= StHold;
            end else begin
              ovf_q   <= (cnt_d > CntMax);
              short_q <= (cnt_d < CntMin);
              state_q <= StIdle;
            end
          end
        end
        StHold: begin
          if (hold_q == 8'd0) begin
            rdy_q   <= 1'b0;
            state_q <= StIdle;
          end else begin
            hold_q <= hold_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef RFID_CRC16_CHECK_EN
  logic [15:0] crc_q, crc_d;
  logic        crc_ok_q;

  always_comb begin
    crc_d = crc_q;
    if (bus.bit_valid) begin
      crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ bus.bit_in) ? 16'h1021 : 16'h0000);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crc_q    <= 16'hFFFF;
      crc_ok_q <= 1'b1;
    end else if (bus.frame_start) begin
      crc_q <= 16'hFFFF;
    end else if (state_q == StRecv) begin
      crc_q <= crc_d;
      if (accept) crc_ok_q <= (crc_d == 16'h1D0F);
    end
  end

  assign bus.crc_ok = crc_ok_q;
`else
  assign bus.crc_ok = 1'b1;
`endif

  assign bus.packet_out   = pkt_q;
  assign bus.op_code      = opc_q;
  assign bus.packet_rdy   = rdy_q;
  assign bus.bit_count    = len_q;
  assign bus.overflow_err = ovf_q;
  assign bus.short_err    = short_q;

endmodule
